// File: rtl/pkt_ingress_framer_if.sv
// pkt_ingress_framer_if: payload stream in, hydra write framing and counters out
interface pkt_ingress_framer_if #(parameter int DATA_W = 16);
  logic s_valid, s_ready, s_last, pause, wr_sop, wr_vld, wr_eop;
  logic [DATA_W-1:0] s_data, wr_data;
  logic [3:0] s_dest;
  logic [2:0] s_prio;
  logic [15:0] pkt_count, drop_count;
  modport master (
    output s_valid, s_data, s_last, s_dest, s_prio, pause,
    input s_ready, wr_sop, wr_vld, wr_eop, wr_data, pkt_count, drop_count
  );
  modport slave (
    input s_valid, s_data, s_last, s_dest, s_prio, pause,
    output s_ready, wr_sop, wr_vld, wr_eop, wr_data, pkt_count, drop_count
  );
endinterface

// File: rtl/pkt_ingress_framer.sv
// pkt_ingress_framer: store-and-forward stream to hydra write-port framer
module pkt_ingress_framer #(
  parameter int DATA_W = 16,
  parameter int MAX_LEN = 511,
  parameter int ADDR_W = 9
) (
  input logic clk,
  input logic rst_n,
  pkt_ingress_framer_if.slave bus
);
  typedef enum logic [2:0] {COLLECT, DISCARD, ARM, SOP, HDR, DATA, EOP} state_t;
  state_t state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic [8:0] len_q, len_d;
  logic [3:0] dest_q, dest_d;
  logic [2:0] prio_q, prio_d;
  logic s_ready_q, s_ready_d, wr_sop_q, wr_sop_d, wr_vld_q, wr_vld_d, wr_eop_q, wr_eop_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [15:0] pkt_q, pkt_d, drop_q, drop_d;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic acc, wr_en;
  always_comb begin
    acc = bus.s_valid && s_ready_q;
    wr_en = !rst_n && acc && state_q == COLLECT && cnt_q < 10'(MAX_LEN);
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    dest_d = dest_q;
    prio_d = prio_q;
    pkt_d = pkt_q;
    drop_d = drop_q;
    case (state_q)
      COLLECT: if (acc) begin
        dest_d = cnt_q == '0 ? bus.s_dest : dest_q;
        prio_d = cnt_q == '0 ? bus.s_prio : prio_q;
        cnt_d = cnt_q + 10'd1;
        if (cnt_q == 10'(MAX_LEN)) begin
          state_d = bus.s_last ? COLLECT : DISCARD;
          drop_d = bus.s_last ? drop_q + 16'(drop_q != '1) : drop_q;
          cnt_d = '0;
        end else if (bus.s_last) begin
          state_d = ARM;
          len_d = cnt_q[8:0] + 9'd1;
          cnt_d = '0;
        end
      end
      DISCARD: if (acc && bus.s_last) begin
        state_d = COLLECT;
        drop_d = drop_q + 16'(drop_q != '1);
      end
      ARM: state_d = bus.pause ? ARM : SOP;
      SOP: state_d = HDR;
      HDR: state_d = DATA;
      DATA: begin
        state_d = cnt_q[8:0] + 9'd1 == len_q ? EOP : DATA;
        cnt_d = cnt_q[8:0] + 9'd1 == len_q ? '0 : cnt_q + 10'd1;
      end
      EOP: begin
        state_d = COLLECT;
        pkt_d = pkt_q + 16'(pkt_q != '1);
      end
      default: state_d = COLLECT;
    endcase
    s_ready_d = state_d == COLLECT || state_d == DISCARD;
    wr_sop_d = state_d == SOP;
    wr_vld_d = state_d == HDR || state_d == DATA;
    wr_eop_d = state_d == EOP;
    wr_data_d = state_d == HDR ? DATA_W'({len_d, prio_d, dest_d}) :
                state_d == DATA ? mem[cnt_d[ADDR_W-1:0]] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= COLLECT;
      cnt_q <= '0;
      len_q <= '0;
      dest_q <= '0;
      prio_q <= '0;
      pkt_q <= '0;
      drop_q <= '0;
      s_ready_q <= 1'b0;
      wr_sop_q <= 1'b0;
      wr_vld_q <= 1'b0;
      wr_eop_q <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      dest_q <= dest_d;
      prio_q <= prio_d;
      pkt_q <= pkt_d;
      drop_q <= drop_d;
      s_ready_q <= s_ready_d;
      wr_sop_q <= wr_sop_d;
      wr_vld_q <= wr_vld_d;
      wr_eop_q <= wr_eop_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt_q[ADDR_W-1:0]] <= bus.s_data;
  end
  assign bus.s_ready = s_ready_q;
  assign bus.wr_sop = wr_sop_q;
  assign bus.wr_vld = wr_vld_q;
  assign bus.wr_eop = wr_eop_q;
  assign bus.wr_data = wr_data_q;
  assign bus.pkt_count = pkt_q;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_pkt_ingress_framer.sv
// tb_pkt_ingress_framer: randomized scoreboard bench for pkt_ingress_framer
module tb_pkt_ingress_framer;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  pkt_ingress_framer_if #(.DATA_W(16)) bus ();
  pkt_ingress_framer #(.DATA_W(16), .MAX_LEN(511), .ADDR_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pkt_m = 0;
  int drop_m = 0;
  int t_last = 0;
  int t_len = 0;
  logic [18:0] exp_q [$];
  logic [15:0] last_hdr = '0;
  bit mon_en = 0;
  bit lat_chk = 0;
  bit in_frame = 0;
  bit hdr_next = 0;
  bit prev_pause = 0;
  bit prev_eop = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [18:0] obs;
    obs = {bus.wr_sop, bus.wr_vld, bus.wr_eop, bus.wr_data};
    if (!mon_en) begin
      exp_q.delete();
      in_frame = 0;
      hdr_next = 0;
      prev_eop = 0;
    end else begin
      if (prev_eop && lat_chk) check("rdy_back", bus.s_ready, 1);
      if (bus.wr_sop || bus.wr_vld || bus.wr_eop) begin
        check("frame", obs, exp_q.size() != 0 ? exp_q.pop_front() : 19'h7FFFF);
        check("rdy_busy", bus.s_ready, 0);
        if (bus.wr_sop) check("sop_pause", prev_pause, 0);
        if (bus.wr_sop && lat_chk) check("sop_lat", cyc - t_last, 2);
        if (bus.wr_eop && lat_chk) check("eop_lat", cyc - t_last, t_len + 4);
        if (hdr_next) last_hdr = bus.wr_data;
        hdr_next = bus.wr_sop;
        in_frame = bus.wr_sop ? 1'b1 : bus.wr_eop ? 1'b0 : in_frame;
      end else check("idle_gap", in_frame, 0);
      prev_eop = bus.wr_eop;
    end
    prev_pause = bus.pause;
  end
  task automatic send_pkt(input int n, input logic [3:0] d, input logic [2:0] p, input int mode);
    logic [15:0] w;
    logic [15:0] pay [$];
    logic [8:0] nl;
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(3) == 0) begin
        bus.s_valid = 0;
        @(posedge clk);
        #1;
      end
      w = mode == 1 ? 16'(i) : mode == 2 ? 16'hBEEF : 16'($urandom);
      bus.s_valid = 1;
      bus.s_data = w;
      bus.s_last = (i == n - 1);
      bus.s_dest = i == 0 ? d : 4'($urandom);
      bus.s_prio = i == 0 ? p : 3'($urandom);
      @(negedge clk);
      check("s_ready", bus.s_ready, 1);
      if (i == n - 1) t_last = cyc;
      @(posedge clk);
      #1;
      pay.push_back(w);
    end
    bus.s_valid = 0;
    bus.s_last = 0;
    t_len = n;
    nl = 9'(n);
    if (n > 511) drop_m++;
    else begin
      exp_q.push_back({3'b100, 16'h0000});
      exp_q.push_back({3'b010, nl, p, d});
      foreach (pay[k]) exp_q.push_back({3'b010, pay[k]});
      exp_q.push_back({3'b001, 16'h0000});
      pkt_m++;
    end
  endtask
  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || in_frame) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) check("idle_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic check_counts();
    @(negedge clk);
    check("pkt_count", bus.pkt_count, pkt_m);
    check("drop_count", bus.drop_count, drop_m);
    @(posedge clk);
    #1;
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_rdy"}, bus.s_ready, 0);
    check({tag, "_sop"}, bus.wr_sop, 0);
    check({tag, "_vld"}, bus.wr_vld, 0);
    check({tag, "_eop"}, bus.wr_eop, 0);
    check({tag, "_data"}, bus.wr_data, 0);
    check({tag, "_pkt"}, bus.pkt_count, 0);
    check({tag, "_drop"}, bus.drop_count, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    bus.s_valid = 0;
    bus.s_data = '0;
    bus.s_last = 0;
    bus.s_dest = '0;
    bus.s_prio = '0;
    bus.pause = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("rst");
    @(posedge clk);
    #1;
    rst_n = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rdy_after_rst", bus.s_ready, 1);
    @(posedge clk);
    #1;
    mon_en = 1;
    lat_chk = 1;
    send_pkt(66, 4'd3, 3'd4, 1);
    wait_idle();
    check("hdr_66", last_hdr, 16'h2143);
    check_counts();
    lat_chk = 0;
    bus.pause = 1;
    send_pkt(64, 4'd4, 3'd4, 0);
    repeat (10) begin
      @(negedge clk);
      check("paused_rdy", bus.s_ready, 0);
      check("paused_sop", bus.wr_sop, 0);
      @(posedge clk);
      #1;
    end
    bus.pause = 0;
    wait_idle();
    check("hdr_64", last_hdr, 16'h2044);
    check_counts();
    lat_chk = 1;
    send_pkt(1, 4'd15, 3'd7, 2);
    wait_idle();
    check("hdr_1", last_hdr, 16'h00FF);
    lat_chk = 0;
    send_pkt(513, 4'd9, 3'd1, 1);
    wait_idle();
    check_counts();
    lat_chk = 1;
    send_pkt(2, 4'd6, 3'd2, 0);
    wait_idle();
    check("hdr_2", last_hdr, 16'h0126);
    send_pkt(512, 4'd1, 3'd3, 0);
    wait_idle();
    send_pkt(511, 4'd2, 3'd5, 0);
    wait_idle();
    check("hdr_511", last_hdr, 16'hFFD2);
    check_counts();
    send_pkt(10, 4'd7, 3'd6, 0);
    repeat (3) @(posedge clk);
    #1;
    bus.pause = 1;
    wait_idle();
    bus.pause = 0;
    check_counts();
    lat_chk = 0;
    send_pkt(64, 4'd8, 3'd0, 0);
    repeat (25) @(posedge clk);
    #1;
    mon_en = 0;
    rst_n = 1;
    @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    check_quiet("mid_rst");
    pkt_m = 0;
    drop_m = 0;
    @(posedge clk);
    #1;
    mon_en = 1;
    lat_chk = 1;
    send_pkt(3, 4'd5, 3'd1, 0);
    wait_idle();
    check("hdr_3", last_hdr, 16'h0195);
    check_counts();
    for (int r = 0; r < 10; r++) begin
      int n;
      bit pz;
      n = $urandom_range(1, 40);
      pz = 1'($urandom_range(1));
      lat_chk = !pz;
      bus.pause = pz;
      send_pkt(n, 4'($urandom), 3'($urandom), 0);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
      bus.pause = 0;
      wait_idle();
    end
    check_counts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pkt_ingress_framer.md
Name: pkt_ingress_framer

Overview:
- Per-port ingress framer that sits directly upstream of one write port of the hydra switch. It turns a simple valid/ready/last payload stream into the hydra write framing: wr_sop, a header word, payload words, then wr_eop.
- Store-and-forward: it buffers one whole packet so the header length field is exact. It holds the start of a frame while the switch asserts pause for that port.
- Sixteen instances feed the 16 hydra write ports.

Parameters:
- DATA_W, 16, payload and wr_data width; must be 16 for the hydra header layout.
- MAX_LEN, 511, maximum payload words per packet; must be in 1..511 to fit the 9-bit length field.
- ADDR_W, 9, buffer address width; must satisfy 2^ADDR_W >= MAX_LEN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-high reset (asserted = 1), sampled on clk.
- s_valid  in  1  input beat valid.
- s_ready  out  1  framer can accept a beat.
- s_data  in  DATA_W  payload word.
- s_last  in  1  final beat of the packet.
- s_dest  in  4  destination port; sampled on the first beat of a packet only.
- s_prio  in  3  priority; sampled on the first beat of a packet only.
- pause  in  1  hydra back-pressure for this port.
- wr_sop  out  1  start-of-packet strobe to hydra.
- wr_vld  out  1  wr_data valid.
- wr_eop  out  1  end-of-packet strobe.
- wr_data  out  DATA_W  header or payload word.
- pkt_count  out  16  packets emitted; saturates at 16'hFFFF.
- drop_count  out  16  oversize packets dropped; saturates at 16'hFFFF.

Behaviour:
- Reset values, driven while rst_n=1 and in the cycle after it is sampled:
  - s_ready=0, wr_sop=0, wr_vld=0, wr_eop=0, wr_data=0, pkt_count=0, drop_count=0.
  - FSM returns to COLLECT; buffer contents and any partial packet are discarded.
  - s_ready=1 from the first cycle with rst_n=0.
- A beat is accepted when s_valid&&s_ready. s_ready=1 only in COLLECT and DISCARD.
- COLLECT:
  - Write accepted beats to buffer[beat_cnt]; beat_cnt counts up from 0.
  - On the first beat, latch s_dest and s_prio.
  - On an accepted s_last with total beats L <= MAX_LEN, go to ARM.
  - On the accepted beat number MAX_LEN+1 without s_last, go to DISCARD. If that beat also carries s_last, drop immediately.
- DISCARD:
  - Accept and discard beats until s_last.
  - On s_last: drop_count += 1 (saturating), return to COLLECT.
  - No wr_* activity at any point for a dropped packet.
- ARM:
  - s_ready=0.
  - If pause=0, go to SOP next cycle; otherwise wait.
  - pause is sampled only in ARM.
- SOP: wr_sop=1, wr_vld=0, wr_data=0, for exactly 1 cycle.
- HDR: wr_vld=1, wr_data={L[8:0], prio[2:0], dest[3:0]}, for 1 cycle.
- DATA:
  - wr_vld=1, wr_data=buffer[0..L-1] in order, one word per cycle, L cycles, no bubbles.
  - pause is ignored in DATA.
- EOP:
  - wr_eop=1, wr_vld=0, wr_data=0, for 1 cycle.
  - pkt_count += 1 (saturating) in this cycle; return to COLLECT.
- Latency: if s_last is accepted in cycle T and pause=0:
  - ARM at T+1, wr_sop at T+2, header at T+3.
  - Payload in T+4..T+3+L, wr_eop at T+4+L.
  - s_ready=1 again at T+5+L.
- wr_sop, wr_vld and wr_eop are mutually exclusive in every cycle. All outputs are registered.
- Buffer: single port-pair RAM of depth 2^ADDR_W, written in COLLECT and read in DATA. Never read and written in the same packet phase.
- Reset mid-operation (any state) aborts the frame with no wr_eop; counters clear.

Test Plan:
1. 66 beats 0..65, dest=3, prio=4, pause=0 -> wr_sop at T+2; header 16'h2143 at T+3; payload 0..65 on T+4..T+69; wr_eop at T+70; pkt_count=1.
2. 64 beats, dest=4, prio=4, pause=1 from T to T+10 -> s_ready=0 and no wr_sop while paused; wr_sop 1 cycle after ARM samples pause=0; header 16'h2044; 64 payload words then wr_eop.
3. 1 beat 16'hBEEF, dest=15, prio=7 -> wr_sop, then header 16'h00FF, then 16'hBEEF, then wr_eop on 4 consecutive cycles.
4. 513 beats with s_last on beat 513, MAX_LEN=511 -> no wr_* activity; s_ready=1 throughout; drop_count=1, pkt_count unchanged. A following 2-beat packet frames normally with header length 2.
5. pause asserted during the DATA phase of a 10-word packet -> all 10 words and wr_eop emitted without stall.
6. rst_n=1 for 1 cycle mid-DATA of a 64-word packet -> next cycle all wr_* outputs 0 and both counters 0, with no wr_eop. A following 3-word packet (dest=5, prio=1) emits header 16'h0195 and completes.
